// File: rtl/demux2_buf_pkg.sv
// Shared definitions for the buffered 1-to-2 demux: default sizing and route encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux2_buf_pkg;

  // Default word width and per-port FIFO depth.
  localparam int DEMUX_WIDTH = 32;
  localparam int DEMUX_DEPTH = 2;

  // Route select encoding carried on c1.
  typedef enum logic {
    PORT2 = 1'b0,
    PORT1 = 1'b1
  } port_sel_e;

endpackage : demux2_buf_pkg

// File: rtl/demux2_buf_fifo.sv
// Small in-order FIFO with a registered head word that holds its last value when empty.
// Latency: a word pushed at edge k is visible on head (empty=0) after edge k.
// Backpressure: push is ignored when full; pop is ignored when empty.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   push        write push_data to the tail (honoured only when not full)
//   push_data   word to write
//   full        count == DEPTH (from registered count)
//   pop         remove the head word (honoured only when not empty)
//   head        registered head word; 0 after reset, holds last value when empty
//   empty       count == 0 (from registered count)
module demux_fifo
  import demux2_buf_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] head_q;

  logic             do_push;
  logic             do_pop;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] head_next;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = head_q;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointer wraps by natural overflow.
  assign rd_next  = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign cnt_next = count + CNT_W'(do_push) - CNT_W'(do_pop);

  // Head register tracks the entry at rd_next. When rd_next lands on the
  // slot being written this cycle (FIFO empty after any pop), the incoming
  // word bypasses the array. When nothing remains, the last head is held.
  always_comb begin
    head_next = head_q;
    if (cnt_next != '0) begin
      if (do_push && (rd_next == wr_ptr)) begin
        head_next = push_data;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      rd_ptr <= rd_next;
      count  <= cnt_next;
      head_q <= head_next;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule : demux_fifo

// File: rtl/demux2_buf.sv
// Buffered 1-to-2 steering: each accepted word goes to port 1 (c1=1) or port 2 (c1=0).
// Latency: word accepted at edge k shows validN=1 after edge k; no data_in->data_outN path.
// Backpressure: in_ready reflects only the selected port's FIFO space, never ready1/ready2.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   data_in, c1, in_valid producer word, route select, valid
//   in_ready              selected FIFO has space
//   data_out1/valid1/ready1  consumer 1 handshake
//   data_out2/valid2/ready2  consumer 2 handshake
module demux2_buf
  import demux2_buf_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             c1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid1,
  input  logic             ready1,
  output logic [WIDTH-1:0] data_out2,
  output logic             valid2,
  input  logic             ready2
);

  port_sel_e sel;
  logic      full1;
  logic      full2;
  logic      empty1;
  logic      empty2;
  logic      push1;
  logic      push2;

  assign sel = port_sel_e'(c1);

  // Space check follows c1 combinationally so a stalled producer that
  // retargets sees the new port's status in the same cycle.
  assign in_ready = (sel == PORT1) ? ~full1 : ~full2;

  assign push1 = in_valid & (sel == PORT1) & ~full1;
  assign push2 = in_valid & (sel == PORT2) & ~full2;

  assign valid1 = ~empty1;
  assign valid2 = ~empty2;

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (data_in),
    .full      (full1),
    .pop       (ready1),
    .head      (data_out1),
    .empty     (empty1)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push2),
    .push_data (data_in),
    .full      (full2),
    .pop       (ready2),
    .head      (data_out2),
    .empty     (empty2)
  );

endmodule : demux2_buf

// File: tb/tb_demux2_buf.sv
// Directed and scoreboarded checks for demux2_buf (WIDTH=32, DEPTH=2).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_demux2_buf;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         c1;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_out1;
  logic         valid1;
  logic         ready1;
  logic [W-1:0] data_out2;
  logic         valid2;
  logic         ready2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux2_buf #(.WIDTH(W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .c1        (c1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out1 (data_out1),
    .valid1    (valid1),
    .ready1    (ready1),
    .data_out2 (data_out2),
    .valid2    (valid2),
    .ready2    (ready2)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle push; caller guarantees the target FIFO has space.
  task automatic push_word(input logic sel, input logic [W-1:0] d);
    in_valid = 1'b1;
    c1       = sel;
    data_in  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  initial begin
    rst_n    = 1'b0;
    data_in  = '0;
    c1       = 1'b0;
    in_valid = 1'b0;
    ready1   = 1'b0;
    ready2   = 1'b0;

    // ---- reset state ----
    #12;
    check("rst_valid1", valid1, 0);
    check("rst_valid2", valid2, 0);
    check("rst_data1", data_out1, 0);
    check("rst_data2", data_out2, 0);
    rst_n = 1'b1;
    tick();

    // ---- steering ----
    ready1 = 1'b1;
    ready2 = 1'b1;
    in_valid = 1'b1; c1 = 1'b1; data_in = 32'hDEADBEEF;
    #1 check("steer_rdy1", in_ready, 1);
    tick();
    check("steer_v1", valid1, 1);
    check("steer_d1", data_out1, 32'hDEADBEEF);
    check("steer_v2_idle", valid2, 0);
    c1 = 1'b0; data_in = 32'h12345678;
    tick();
    in_valid = 1'b0;
    check("steer_v2", valid2, 1);
    check("steer_d2", data_out2, 32'h12345678);
    check("steer_v1_popped", valid1, 0);
    check("steer_d1_hold", data_out1, 32'hDEADBEEF);
    tick();
    check("steer_v2_popped", valid2, 0);
    check("steer_d2_hold", data_out2, 32'h12345678);

    // ---- back-pressure ----
    ready1 = 1'b0;
    push_word(1'b1, 32'h1);
    push_word(1'b1, 32'h2);
    in_valid = 1'b1; c1 = 1'b1; data_in = 32'h3;
    #1 check("bp_full_rdy", in_ready, 0);
    tick();
    check("bp_head1", data_out1, 32'h1);
    check("bp_v2_none", valid2, 0);
    c1 = 1'b0;
    #1 check("bp_switch_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_v2", valid2, 1);
    check("bp_d2", data_out2, 32'h3);
    ready1 = 1'b1;
    tick();
    check("bp_pop1_d", data_out1, 32'h2);
    check("bp_pop1_v", valid1, 1);
    check("bp_v2_drained", valid2, 0);
    tick();
    check("bp_v1_empty", valid1, 0);

    // ---- ordering under stall ----
    ready1 = 1'b0;
    push_word(1'b1, 32'hA1);
    push_word(1'b1, 32'hA2);
    check("ord_head", data_out1, 32'hA1);
    ready1 = 1'b1;
    tick();
    check("ord_second", data_out1, 32'hA2);
    check("ord_second_v", valid1, 1);
    tick();
    check("ord_empty", valid1, 0);
    check("ord_hold", data_out1, 32'hA2);

    // ---- simultaneous push/pop on port 2 ----
    ready2 = 1'b0;
    push_word(1'b0, 32'hAF);
    check("pp_pre_d", data_out2, 32'hAF);
    ready2 = 1'b1;
    in_valid = 1'b1; c1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data_in = 32'hB0 + W'(i);
      #1 check("pp_rdy", in_ready, 1);
      tick();
      check("pp_d", data_out2, 32'hB0 + W'(i));
      check("pp_v", valid2, 1);
    end
    in_valid = 1'b0;
    tick();
    check("pp_end_v", valid2, 0);
    check("pp_end_hold", data_out2, 32'hBF);

    // ---- mid-cycle reset with both FIFOs full ----
    ready1 = 1'b0;
    ready2 = 1'b0;
    push_word(1'b1, 32'h11);
    push_word(1'b1, 32'h22);
    push_word(1'b0, 32'h33);
    push_word(1'b0, 32'h44);
    check("mr_pre_v1", valid1, 1);
    check("mr_pre_d2", data_out2, 32'h33);
    #2 rst_n = 1'b0;
    #1;
    check("mr_v1", valid1, 0);
    check("mr_v2", valid2, 0);
    check("mr_d1", data_out1, 0);
    check("mr_d2", data_out2, 0);
    #2 rst_n = 1'b1;
    c1 = 1'b1;
    #1 check("mr_rdy_c1", in_ready, 1);
    c1 = 1'b0;
    #1 check("mr_rdy_c0", in_ready, 1);
    tick();
    check("mr_post_v1", valid1, 0);
    check("mr_post_v2", valid2, 0);

    // ---- random traffic against per-port scoreboard ----
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic exp_rdy;
      logic acc;
      logic pop1;
      logic pop2;
      in_valid = 1'($urandom_range(0, 1));
      c1       = 1'($urandom_range(0, 1));
      ready1   = ($urandom_range(0, 3) != 0);
      ready2   = ($urandom_range(0, 3) != 0);
      data_in  = $urandom;
      #1;
      exp_rdy = c1 ? (q1.size() < 2) : (q2.size() < 2);
      check("rnd_rdy", in_ready, exp_rdy);
      check("rnd_v1", valid1, q1.size() != 0);
      check("rnd_v2", valid2, q2.size() != 0);
      if (q1.size() != 0) check("rnd_d1", data_out1, q1[0]);
      if (q2.size() != 0) check("rnd_d2", data_out2, q2[0]);
      acc  = in_valid && exp_rdy;
      pop1 = ready1 && (q1.size() != 0);
      pop2 = ready2 && (q2.size() != 0);
      if (pop1) void'(q1.pop_front());
      if (pop2) void'(q2.pop_front());
      if (acc) begin
        if (c1) q1.push_back(data_in);
        else    q2.push_back(data_in);
      end
      @(posedge clk);
      #1;
    end

    // Drain: everything left must come out in order, then both ports go idle.
    in_valid = 1'b0;
    ready1   = 1'b1;
    ready2   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("drain_v1", valid1, q1.size() != 0);
      check("drain_v2", valid2, q2.size() != 0);
      if (q1.size() != 0) begin
        check("drain_d1", data_out1, q1[0]);
        void'(q1.pop_front());
      end
      if (q2.size() != 0) begin
        check("drain_d2", data_out2, q2[0]);
        void'(q2.pop_front());
      end
      tick();
    end
    check("drain_final_v1", valid1, 0);
    check("drain_final_v2", valid2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux2_buf
